uart_tx_pattern_gen: RTL and testbench

Parametrised UART transmit stimulus generator. Streams a compile-time message (repeat or one-shot) or an incrementing byte counter into the `uart` block's transmit handshake. It adds a programmable inter-byte gap, an acceptance timeout with retry, and status outputs. It sits between board-level enable/mode controls and `uart` (`tx_data_i` / `tx_trigger_i` / `tx_complete_o`), replacing fixed two-character test drivers.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_tx_pattern_gen.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_pattern_gen.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared encodings for the UART transmit pattern generator.
//   - mode_e     : latched run mode (repeat message, one-shot message, counter bytes)
//   - tx_state_e : generator FSM state, also exported on the debug port
//   - decode_mode: maps the raw 2-bit mode input onto mode_e (3 folds onto repeat)
package uart_pkg;

    typedef enum logic [1:0] {
        MODE_REPEAT  = 2'd0,
        MODE_ONESHOT = 2'd1,
        MODE_COUNT   = 2'd2
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4,
        ST_NEXT      = 3'd5,
        ST_DONE      = 3'd6
    } tx_state_e;

    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return MODE_ONESHOT;
            2'd2:    return MODE_COUNT;
            default: return MODE_REPEAT;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_pattern_gen.sv
// uart_tx_pattern_gen
//   Drives the transmit handshake of the uart block with either a fixed
//   message (repeated or one-shot) or an incrementing byte counter. Adds a
//   programmable idle gap after every completed byte and retries a byte when
//   the UART does not accept a trigger within ACK_TIMEOUT clocks.
//
// Handshake: tx_trigger_o is a one-cycle strobe issued only while
//   tx_complete_i (UART idle) is high; tx_data_o is valid in that cycle and
//   held until the next strobe. The UART accepts by dropping tx_complete_i,
//   and the byte is finished when tx_complete_i returns high.
//
// Ports
//   clk_i          : clock
//   rst_i          : synchronous active-high reset
//   enable_i       : run request (level)
//   mode_i         : 0 repeat, 1 one-shot, 2 counter, 3 = repeat
//   tx_complete_i  : UART idle/ready level
//   tx_data_o      : byte to transmit
//   tx_trigger_o   : one-cycle send strobe
//   busy_o         : high whenever the FSM is not in IDLE
//   done_o         : one-cycle pulse when a one-shot message has finished
//   sent_count_o   : completed bytes since reset (wraps)
//   retry_count_o  : acceptance timeouts since reset (saturates)
//   state_o        : current FSM state (debug)
module uart_tx_pattern_gen
    import uart_pkg::*;
#(
    parameter int                   MSG_LEN     = 2,
    parameter logic [8*MSG_LEN-1:0] MSG         = "AC",
    parameter int                   GAP_CYCLES  = 0,
    parameter int                   ACK_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [1:0]  mode_i,
    input  logic        tx_complete_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_trigger_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] sent_count_o,
    output logic [7:0]  retry_count_o,
    output tx_state_e   state_o
);

    localparam int                IDX_W    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(MSG_LEN - 1);
    // The shared down-counter is loaded with N-1 so a state waits exactly N clocks.
    localparam logic [15:0]       GAP_LOAD = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [15:0]       ACK_LOAD = 16'(ACK_TIMEOUT - 1);

    tx_state_e        state;
    mode_e            mode_q;
    logic [IDX_W-1:0] idx;
    logic [7:0]       cnt_byte;
    logic [15:0]      timer;
    logic [7:0]       msg_byte;

    // Byte 0 is the leftmost character of MSG.
    assign msg_byte = MSG[(8*MSG_LEN-1) - 8*int'(idx) -: 8];

    assign busy_o  = (state != ST_IDLE);
    assign state_o = state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            mode_q        <= MODE_REPEAT;
            idx           <= '0;
            cnt_byte      <= 8'h00;
            timer         <= 16'd0;
            tx_data_o     <= 8'h00;
            tx_trigger_o  <= 1'b0;
            done_o        <= 1'b0;
            sent_count_o  <= 16'd0;
            retry_count_o <= 8'd0;
        end else begin
            tx_trigger_o <= 1'b0;
            done_o       <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (enable_i) begin
                        mode_q <= decode_mode(mode_i);
                        if (decode_mode(mode_i) == MODE_ONESHOT) begin
                            idx <= '0;
                        end
                        state <= ST_ARM;
                    end
                end

                ST_ARM: begin
                    // A run stop is honoured before launching; a low
                    // tx_complete_i simply holds here until the UART is idle.
                    if (!enable_i) begin
                        state <= ST_IDLE;
                    end else if (tx_complete_i) begin
                        tx_data_o    <= (mode_q == MODE_COUNT) ? cnt_byte : msg_byte;
                        tx_trigger_o <= 1'b1;
                        timer        <= ACK_LOAD;
                        state        <= ST_WAIT_ACK;
                    end
                end

                ST_WAIT_ACK: begin
                    if (!tx_complete_i) begin
                        state <= ST_WAIT_DONE;
                    end else if (timer == 16'd0) begin
                        // Not accepted: resend the same byte, index/counter untouched.
                        if (retry_count_o != 8'hFF) begin
                            retry_count_o <= retry_count_o + 8'd1;
                        end
                        state <= ST_ARM;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end

                ST_WAIT_DONE: begin
                    if (tx_complete_i) begin
                        sent_count_o <= sent_count_o + 16'd1;
                        if (mode_q == MODE_COUNT) begin
                            cnt_byte <= cnt_byte + 8'd1;
                        end else begin
                            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                        end
                        if (GAP_CYCLES > 0) begin
                            timer <= GAP_LOAD;
                            state <= ST_GAP;
                        end else begin
                            state <= ST_NEXT;
                        end
                    end
                end

                ST_GAP: begin
                    if (timer == 16'd0) begin
                        state <= ST_NEXT;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end

                ST_NEXT: begin
                    // One-shot always starts at index 0, so a wrap back to 0
                    // means the final byte has just completed.
                    if (mode_q == MODE_ONESHOT && idx == '0) begin
                        done_o <= 1'b1;
                        state  <= ST_DONE;
                    end else if (!enable_i) begin
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_ARM;
                    end
                end

                ST_DONE: begin
                    if (!enable_i) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_pattern_gen.sv
// tb_uart_tx_pattern_gen
//   Stimulus tasks push the bytes the generator must emit into exp_q; a
//   behavioural UART process pops and compares on every trigger and also
//   plays the UART handshake (busy for a random number of clocks).
module tb_uart_tx_pattern_gen;
  import uart_pkg::*;

  localparam int MSG_LEN = 3;
  localparam logic [8*MSG_LEN-1:0] MSG = "XYZ";
  localparam int GAP = 5;
  localparam int ACK = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        enable;
  logic [1:0]  mode;
  logic        tx_complete;
  logic [7:0]  tx_data;
  logic        tx_trigger;
  logic        busy;
  logic        done;
  logic [15:0] sent_count;
  logic [7:0]  retry_count;
  tx_state_e   state;

  uart_tx_pattern_gen #(
    .MSG_LEN(MSG_LEN), .MSG(MSG), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .mode_i(mode),
    .tx_complete_i(tx_complete), .tx_data_o(tx_data), .tx_trigger_o(tx_trigger),
    .busy_o(busy), .done_o(done), .sent_count_o(sent_count),
    .retry_count_o(retry_count), .state_o(state)
  );

  // scoreboard bookkeeping
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // reference model: message characters, byte counter, expected counts
  logic [7:0]  msg_chars [MSG_LEN] = '{"X", "Y", "Z"};
  int          ref_idx   = 0;
  logic [7:0]  ref_cnt   = 8'h00;
  logic [15:0] ref_sent  = 16'd0;
  logic [7:0]  ref_retry = 8'd0;

  // monitor / UART model state
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int acc_cnt    = 0;
  int trig_total = 0;
  int done_cnt   = 0;
  int busy_min   = 1;
  int busy_max   = 10;
  bit ignore_next = 0;
  bit chain       = 0;
  bit retry_pend  = 0;
  int rise_cyc    = 0;
  int ign_cyc     = 0;
  logic prev_trig = 1'b0;

  initial begin
    tx_complete = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_trigger) begin
        trig_total++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_trigger: actual data=%0h required no trigger", tx_data);
        end else begin
          check("tx_data", tx_data, exp_q[0]);
          if (chain) check("byte_spacing", cyc - rise_cyc, 3 + GAP);
          if (retry_pend) begin
            // ACK clocks in WAIT_ACK, then one clock in ARM before the strobe
            check("retry_spacing", cyc - ign_cyc, ACK + 1);
            retry_pend = 0;
          end
          chain = 0;
          if (ignore_next) begin
            ignore_next = 0;
            retry_pend  = 1;
            ign_cyc     = cyc;
          end else begin
            void'(exp_q.pop_front());
            acc_cnt++;
            @(posedge clk); #1 tx_complete = 1'b0;
            repeat ($urandom_range(busy_max, busy_min)) @(posedge clk);
            #1 tx_complete = 1'b1;
            rise_cyc = cyc;
            chain    = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (tx_trigger) check("trigger_single_cycle", prev_trig, 1'b0);
    prev_trig = tx_trigger;
    if (done) done_cnt++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) fail_now(name);
    check({name, "_busy"}, busy, 1'b0);
  endtask

  task automatic check_counts(input string name);
    check({name, "_sent"}, sent_count, ref_sent);
    check({name, "_retry"}, retry_count, ref_retry);
  endtask

  // Run n bytes in mode m, dropping enable once the last byte is accepted.
  task automatic run_bytes(input logic [1:0] m, input int n, input string name);
    int target;
    int k = 0;
    for (int i = 0; i < n; i++) begin
      if (m == 2'd2) begin
        exp_q.push_back(ref_cnt);
        ref_cnt = ref_cnt + 8'd1;
      end else begin
        exp_q.push_back(msg_chars[ref_idx]);
        ref_idx = (ref_idx + 1) % MSG_LEN;
      end
    end
    ref_sent = ref_sent + 16'(n);
    target = acc_cnt + n;
    chain  = 0;
    mode   = m;
    enable = 1'b1;
    while (acc_cnt < target && k < n * (ACK + GAP + 40) + 100) begin
      tick();
      k++;
    end
    if (acc_cnt < target) fail_now({name, "_accept"});
    enable = 1'b0;
    wait_idle(name);
    check_counts(name);
  endtask

  task automatic run_oneshot();
    int d0;
    int t0;
    int k = 0;
    ref_idx = 0;
    for (int i = 0; i < MSG_LEN; i++) begin
      exp_q.push_back(msg_chars[ref_idx]);
      ref_idx = (ref_idx + 1) % MSG_LEN;
    end
    ref_sent = ref_sent + 16'(MSG_LEN);
    d0 = done_cnt;
    t0 = trig_total;
    chain  = 0;
    mode   = 2'd1;
    enable = 1'b1;
    while (done_cnt == d0 && k < 1000) begin
      tick();
      k++;
    end
    if (done_cnt == d0) fail_now("oneshot_done");
    repeat (40) tick();
    check("oneshot_triggers", trig_total - t0, MSG_LEN);
    check("oneshot_done_pulses", done_cnt - d0, 1);
    check("oneshot_hold_busy", busy, 1'b1);
    enable = 1'b0;
    wait_idle("oneshot");
    check_counts("oneshot");
  endtask

  task automatic reset_mid_byte();
    int a0 = acc_cnt;
    int k = 0;
    busy_min = 10;
    busy_max = 10;
    exp_q.push_back(msg_chars[ref_idx]);
    chain  = 0;
    mode   = 2'd0;
    enable = 1'b1;
    while (acc_cnt == a0 && k < 200) begin
      tick();
      k++;
    end
    if (acc_cnt == a0) fail_now("reset_accept");
    repeat (3) tick();
    rst    = 1'b1;
    enable = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_trigger", tx_trigger, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sent", sent_count, 16'd0);
    check("rst_retry", retry_count, 8'd0);
    ref_idx   = 0;
    ref_cnt   = 8'h00;
    ref_sent  = 16'd0;
    ref_retry = 8'd0;
    k = 0;
    while (!tx_complete && k < 100) begin
      tick();
      k++;
    end
    chain    = 0;
    busy_min = 1;
    busy_max = 10;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] m;
    rst    = 1'b1;
    enable = 1'b0;
    mode   = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("init_tx_data", tx_data, 8'h00);
    check("init_trigger", tx_trigger, 1'b0);
    check("init_busy", busy, 1'b0);
    check("init_done", done, 1'b0);
    check("init_sent", sent_count, 16'd0);
    check("init_retry", retry_count, 8'd0);

    busy_min = 10;
    busy_max = 10;
    run_bytes(2'd0, 4, "repeat");
    busy_min = 1;

    ignore_next = 1;
    ref_retry   = ref_retry + 8'd1;
    run_bytes(2'd0, 2, "retry");

    run_oneshot();
    run_bytes(2'd3, $urandom_range(2, 4), "mode3");

    busy_max = 3;
    run_bytes(2'd2, 257, "counter");
    run_bytes(2'd2, 3, "counter_cont");

    for (int r = 0; r < 6; r++) begin
      busy_max = $urandom_range(1, 12);
      case ($urandom_range(0, 2))
        0:       m = 2'd0;
        1:       m = 2'd2;
        default: m = 2'd3;
      endcase
      run_bytes(m, $urandom_range(1, 5), "random");
    end

    reset_mid_byte();
    run_bytes(2'd2, 2, "post_rst_counter");
    run_bytes(2'd0, 2, "post_rst_repeat");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
